divider_array_arbiter: RTL
==========================

DIVIDER_ARRAY_ARBITER -- requirements
Module: divider_array_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: cycles the external combinational 16/8 array-divider core settles before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has a division pending.
REQ-005 req0_n / req1_n  input  16 each  dividend; req0_d / req1_d  input  8 each  divisor.
REQ-006 req0_ready / req1_ready  output  1 each  request accepted this cycle when ANDed with valid.
REQ-007 div_n  output  16, div_d  output  8  operands driven to the external divider core.
REQ-008 div_q  input  8, div_r  input  8  quotient/remainder returned by the core.
REQ-009 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-010 rsp_id  output  1  requester index; rsp_q, rsp_r  output  8 each  results.
REQ-011 rsp_ovf  output  1  quotient overflow flag; rsp_dz  output  1  divide-by-zero flag.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-013 In IDLE, ready SHALL be combinational: only the granted requester sees ready=1; the other sees ready=0.
REQ-014 Grant SHALL be round-robin: with both valid, grant goes to the requester not served last; with one valid, that one wins; after reset requester 0 has priority.
REQ-015 On accepted handshake, n, d, id SHALL be registered, the last-served pointer updated, and the FSM SHALL go IDLE->BUSY with wait counter = WAIT_CYCLES-1.
REQ-016 div_n/div_d SHALL come from the operand registers only, held stable through BUSY and DONE.
REQ-017 In BUSY the counter SHALL decrement each cycle; at count 0, div_q/div_r SHALL be captured into rsp_q/rsp_r and the FSM SHALL go to DONE; request-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
REQ-018 rsp_ovf SHALL be set when n[15:8] >= d (quotient exceeds 8 bits), computed at acceptance; results are still those returned by the core.
REQ-019 In DONE, rsp_valid=1 and all rsp_* SHALL hold until rsp_valid&rsp_ready; then FSM->IDLE, no new request accepted in that same cycle.
REQ-020 No request SHALL be accepted outside IDLE; req*_ready=0 in BUSY and DONE.
REQ-021 A requester dropping valid before acceptance SHALL not be granted; no fairness state changes without a handshake.

Reset
REQ-022 Asserting rst_n low at any time, including mid-BUSY or DONE, SHALL immediately force IDLE and abandon the operation with no response.
REQ-023 Reset values: rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_ovf=0, rsp_dz=0, div_n=0, div_d=0, counter=0, last-served pointer=1 (requester 0 next).

Configuration
REQ-024 Macro DIV_ZERO_DETECT_EN SHALL select divide-by-zero handling.
REQ-025 Defined: d==0 at acceptance SHALL skip BUSY, go IDLE->DONE next cycle with rsp_q=8'hFF, rsp_r=n[7:0], rsp_dz=1, rsp_ovf=1.
REQ-026 Undefined: d==0 SHALL follow the normal BUSY path with core outputs, and rsp_dz SHALL be constant 0.

Verification
REQ-027 req0 n=16'h00C8, d=8'h07, WAIT_CYCLES=2 -> rsp_valid 3 cycles after accept, rsp_id=0, rsp_q=8'h1C, rsp_r=8'h04, ovf=0, dz=0 (exact core model).
REQ-028 req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; rsp_id matches grant order.
REQ-029 rsp_ready held low 5 cycles in DONE -> rsp_* stable, both ready=0; accept follows only after the rsp handshake cycle.
REQ-030 n=16'h0900, d=8'h08 -> rsp_ovf=1.
REQ-031 d=0 with DIV_ZERO_DETECT_EN, n=16'h1234 -> DONE next cycle, q=8'hFF, r=8'h34, dz=1; without macro -> normal latency, dz=0.
REQ-032 rst_n pulsed low mid-BUSY -> rsp_valid never asserts for that request; next request served from requester 0.

Source files
------------

// File: rtl/divider_array_arbiter.sv
// -----------------------------------------------------------------------------
// divider_array_arbiter
//
// Two-requester round-robin front end for an external combinational 16/8
// array divider. One division is in flight at a time:
//   IDLE : grant one requester (combinational ready), register its operands
//   BUSY : hold operands on div_n/div_d for WAIT_CYCLES so the core settles,
//          then capture div_q/div_r
//   DONE : present the response until rsp_valid & rsp_ready
//
// Optional feature (macro DIV_ZERO_DETECT_EN):
//   defined   : divisor 0 bypasses the core; response q=FF, r=n[7:0],
//               dz=1, ovf=1, presented the cycle after acceptance
//   undefined : divisor 0 takes the normal path; rsp_dz is constant 0
//
// Parameters
//   WAIT_CYCLES  core settle time in cycles, 1..15
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqX_valid/_n/_d/_ready    requester X (0/1) handshake and operands
//   div_n, div_d               operands to the external divider core
//   div_q, div_r               results from the external divider core
//   rsp_valid, rsp_ready       response handshake
//   rsp_id, rsp_q, rsp_r       serviced requester and results
//   rsp_ovf, rsp_dz            quotient overflow / divide-by-zero flags
// -----------------------------------------------------------------------------
module divider_array_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic        req1_ready,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic        rsp_ovf,
  output logic        rsp_dz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last;      // requester served most recently
  logic [15:0] r_n;
  logic [7:0]  r_d;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [7:0]  r_rsp_q;
  logic [7:0]  r_rsp_r;
  logic        r_rsp_ovf;
  logic        r_rsp_dz;

  logic        w_idle;
  logic        w_accept;
  logic        w_gnt_id;
  logic [15:0] w_gnt_n;
  logic [7:0]  w_gnt_d;

  // Round-robin: with both requesting, serve the one not served last;
  // otherwise serve whichever is requesting.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_gnt_id = 1'b0;
    if (req0_valid && req1_valid) w_gnt_id = ~r_last;
    else if (req1_valid)          w_gnt_id = 1'b1;
    w_gnt_n = w_gnt_id ? req1_n : req0_n;
    w_gnt_d = w_gnt_id ? req1_d : req0_d;
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_gnt_id;
  assign req1_ready = w_idle && req1_valid &&  w_gnt_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous and clears all state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_n         <= 16'd0;
      r_d         <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_q     <= 8'd0;
      r_rsp_r     <= 8'd0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n       <= w_gnt_n;
            r_d       <= w_gnt_d;
            r_rsp_id  <= w_gnt_id;
            r_last    <= w_gnt_id;
            // High byte >= divisor means the quotient needs more than 8 bits.
            r_rsp_ovf <= (w_gnt_n[15:8] >= w_gnt_d);
            r_cnt     <= CNT_INIT;
            r_rsp_dz  <= 1'b0;
            r_state   <= S_BUSY;
`ifdef DIV_ZERO_DETECT_EN
            if (w_gnt_d == 8'd0) begin
              r_rsp_q     <= 8'hFF;
              r_rsp_r     <= w_gnt_n[7:0];
              r_rsp_dz    <= 1'b1;
              r_rsp_ovf   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_rsp_q     <= div_q;
            r_rsp_r     <= div_r;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_n     = r_n;
  assign div_d     = r_d;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign rsp_r     = r_rsp_r;
  assign rsp_ovf   = r_rsp_ovf;
`ifdef DIV_ZERO_DETECT_EN
  assign rsp_dz    = r_rsp_dz;
`else
  assign rsp_dz    = 1'b0;
  logic w_unused_dz;
  assign w_unused_dz = r_rsp_dz;
`endif

endmodule
